// File: rtl/y_buf_argmax_reader.sv
// Reads back IN_IMG_NUM x CLASS_NUM signed scores from the Y buffer and streams one argmax label per image.
// Optional ARGMAX_SCORE_EN macro adds max_score_o carrying the winning score alongside each label.
module y_buf_argmax_reader #(
  parameter int IN_IMG_NUM       = 10,
  parameter int CLASS_NUM        = 10,
  parameter int Y_BUF_DATA_WIDTH = 32,
  parameter int Y_BUF_ADDR_WIDTH = 32,
  parameter int ADDR_STRIDE      = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_i,
  output logic                        y_rd_en,
  output logic [Y_BUF_ADDR_WIDTH-1:0] y_rd_addr,
  input  logic [Y_BUF_DATA_WIDTH-1:0] y_rd_data,
  output logic                        label_valid_o,
  input  logic                        label_ready_i,
  output logic [3:0]                  label_o,
  output logic [3:0]                  label_img_o,
  output logic                        busy_o,
`ifdef ARGMAX_SCORE_EN
  output logic [Y_BUF_DATA_WIDTH-1:0] max_score_o,
`endif
  output logic                        done_o
);
  localparam int AW = Y_BUF_ADDR_WIDTH;
  localparam int DW = Y_BUF_DATA_WIDTH;

  typedef enum logic [2:0] {IDLE, RD, LAST, EMIT, FIN} state_t;
  state_t state, state_nxt;

  logic [3:0]           img, cls, rd_cls, best_idx;
  logic                 rd_vld, upd, busy_q, done_q;
  logic signed [DW-1:0] best_score;

  wire cls_last = (cls == 4'(CLASS_NUM - 1));
  wire img_last = (img == 4'(IN_IMG_NUM - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = RD;
      RD:      if (cls_last) state_nxt = LAST;
      LAST:    state_nxt = EMIT;
      EMIT:    if (label_ready_i) state_nxt = img_last ? FIN : RD;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    y_rd_en       = (state == RD);
    label_valid_o = (state == EMIT);
    y_rd_addr     = '0;
    if (y_rd_en)
      y_rd_addr = (AW'(img) * AW'(CLASS_NUM) + AW'(cls)) * AW'(ADDR_STRIDE);
    label_o     = label_valid_o ? best_idx : 4'd0;
    label_img_o = label_valid_o ? img : 4'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      img <= '0;
      cls <= '0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          img <= '0;
          cls <= '0;
        end
        RD:   if (!cls_last) cls <= cls + 4'd1;
        EMIT: if (label_ready_i && !img_last) begin
          img <= img + 4'd1;
          cls <= '0;
        end
        default: ;
      endcase
    end
  end

  // Read data lands one cycle after the request; class 0 always seeds the running best.
  assign upd = rd_vld && ((rd_cls == 4'd0) || ($signed(y_rd_data) > best_score));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld     <= 1'b0;
      rd_cls     <= '0;
      best_score <= '0;
      best_idx   <= '0;
    end else begin
      rd_vld <= y_rd_en;
      rd_cls <= cls;
      if (upd) begin
        best_score <= $signed(y_rd_data);
        best_idx   <= rd_cls;
      end
    end
  end

  // busy and done share the FIN edge so busy falls exactly when done pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state == FIN);
      if (state == IDLE && start_i) busy_q <= 1'b1;
      else if (state == FIN)        busy_q <= 1'b0;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;

`ifdef ARGMAX_SCORE_EN
  logic [DW-1:0] max_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 max_q <= '0;
    else if (state_nxt == EMIT) max_q <= upd ? y_rd_data : best_score;
    else                        max_q <= '0;
  end
  assign max_score_o = max_q;
`endif
endmodule
